// File: rtl/squares_vga_pkg.sv
// Shared timing defaults, register-port field codes and the square attribute
// record used by the squares VGA renderer.
package squares_vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Storage width for coordinates; COORD_W (<= 16) selects how much is written.
  localparam int COORD_MAX_W = 16;

  typedef enum logic [1:0] {
    FLD_X     = 2'd0,
    FLD_Y     = 2'd1,
    FLD_SIZE  = 2'd2,
    FLD_COLOR = 2'd3
  } field_e;

  typedef struct packed {
    logic [COORD_MAX_W-1:0] x;
    logic [COORD_MAX_W-1:0] y;
    logic [COORD_MAX_W-1:0] size;
    logic [23:0]            color;
  } square_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/squares_vga_timing.sv
// Pixel-clock divider, raster counters, raw sync/active flags and the
// once-per-frame commit strobe at the start of the first blanking line.
module squares_vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int H_W      = 10,
  parameter int V_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           tick,
  output logic           pix_clk,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hs,
  output logic           vs,
  output logic           active,
  output logic           commit
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div;

  assign tick    = (div == DIV_W'(CLK_DIV - 1));
  assign pix_clk = (32'(div) >= CLK_DIV / 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      if (tick) begin
        div <= '0;
        if (32'(h) == H_TOTAL - 1) begin
          h <= '0;
          if (32'(v) == V_TOTAL - 1) v <= '0;
          else                       v <= v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign hs     = !((32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC));
  assign vs     = !((32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC));
  assign active = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
  // Commit on the first tick of line V_ACTIVE: the whole visible frame is done.
  assign commit = tick && (h == '0) && (32'(v) == V_ACTIVE);

endmodule

// File: rtl/squares_vga_renderer.sv
// Draws up to N_SQ prioritised solid squares over a background colour and
// drives the VGA DAC pins; square attributes are double-buffered per frame.
module squares_vga_renderer
  import squares_vga_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          H_FP     = H_FP_DEF,
  parameter int          H_SYNC   = H_SYNC_DEF,
  parameter int          H_BP     = H_BP_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          V_FP     = V_FP_DEF,
  parameter int          V_SYNC   = V_SYNC_DEF,
  parameter int          V_BP     = V_BP_DEF,
  parameter int          CLK_DIV  = 2,
  parameter int          N_SQ     = 4,
  parameter int          COORD_W  = 10,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_sq,
  input  logic [1:0]  wr_field,
  input  logic [23:0] wr_data,
  output logic        frame_commit,
  output logic        vga_CLK,
  output logic        vga_HS,
  output logic        vga_VS,
  output logic        vga_BLANK,
  output logic        vga_SYNC,
  output logic [7:0]  vga_R,
  output logic [7:0]  vga_G,
  output logic [7:0]  vga_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  // Wide enough that x+size never wraps and the raster position never truncates.
  localparam int CMP_W   = max_int(COORD_MAX_W + 1, max_int(H_W, V_W));

  logic           tick, pix_clk, hs_raw, vs_raw, act_raw, commit;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;

  squares_vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .tick   (tick),
    .pix_clk(pix_clk),
    .h      (h),
    .v      (v),
    .hs     (hs_raw),
    .vs     (vs_raw),
    .active (act_raw),
    .commit (commit)
  );

  square_t shadow_sq [N_SQ];
  square_t active_sq [N_SQ];

  // Write port has no back-pressure: every cycle with wr_en high is accepted,
  // landing in shadow only; a write in the commit cycle misses that commit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < N_SQ; i++) begin
        shadow_sq[i] <= '0;
        active_sq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SQ; i++) begin
        if (commit) active_sq[i] <= shadow_sq[i];
        if (wr_en && (wr_sq == 4'(i))) begin
          case (field_e'(wr_field))
            FLD_X:     shadow_sq[i].x     <= COORD_MAX_W'(wr_data[COORD_W-1:0]);
            FLD_Y:     shadow_sq[i].y     <= COORD_MAX_W'(wr_data[COORD_W-1:0]);
            FLD_SIZE:  shadow_sq[i].size  <= COORD_MAX_W'(wr_data[COORD_W-1:0]);
            FLD_COLOR: shadow_sq[i].color <= wr_data;
            default:   ;
          endcase
        end
      end
    end
  end

  logic [CMP_W-1:0] h_ext, v_ext;
  logic [N_SQ-1:0]  hit;

  assign h_ext = CMP_W'(h);
  assign v_ext = CMP_W'(v);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SQ; i++) begin
      hit[i] = (active_sq[i].size != '0)
            && (h_ext >= CMP_W'(active_sq[i].x))
            && (h_ext <  CMP_W'(active_sq[i].x) + CMP_W'(active_sq[i].size))
            && (v_ext >= CMP_W'(active_sq[i].y))
            && (v_ext <  CMP_W'(active_sq[i].y) + CMP_W'(active_sq[i].size));
    end
  end

  logic [N_SQ-1:0] hit_q;
  logic            hs_q, vs_q, act_q;
  logic [23:0]     pix_color;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hit_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
    end else if (tick) begin
      hit_q <= hit;
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
      act_q <= act_raw;
    end
  end

  // Scan from the top index down so the lowest-index hit is written last.
  always_comb begin
    pix_color = BG_COLOR;
    for (int i = N_SQ - 1; i >= 0; i--) begin
      if (hit_q[i]) pix_color = active_sq[i].color;
    end
    if (!act_q) pix_color = '0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vga_HS    <= 1'b1;
      vga_VS    <= 1'b1;
      vga_BLANK <= 1'b0;
      vga_R     <= '0;
      vga_G     <= '0;
      vga_B     <= '0;
    end else if (tick) begin
      vga_HS    <= hs_q;
      vga_VS    <= vs_q;
      vga_BLANK <= act_q;
      vga_R     <= pix_color[23:16];
      vga_G     <= pix_color[15:8];
      vga_B     <= pix_color[7:0];
    end
  end

  assign vga_CLK      = pix_clk;
  assign vga_SYNC     = 1'b0;
  assign frame_commit = commit;

endmodule

// File: tb/tb_squares_vga_renderer.sv
// Bench for squares_vga_renderer on a shrunken raster: every clock compares
// all outputs against a frame-arithmetic reference model.
module tb_squares_vga_renderer;

  localparam int HA = 32, HF = 2, HSY = 4, HB = 2;
  localparam int VA = 24, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int COMMIT_POS = VA * HT;
  localparam int CLK_DIV = 3;
  localparam int N_SQ = 4;
  localparam int CW = 6;
  localparam logic [23:0] BG = 24'h102030;
  localparam int W = 27;
  localparam logic [W-1:0] RESET_PIX = {1'b1, 1'b1, 1'b0, 24'h000000};

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_sq = '0;
  logic [1:0]  wr_field = '0;
  logic [23:0] wr_data = '0;
  logic        frame_commit, vga_CLK, vga_HS, vga_VS, vga_BLANK, vga_SYNC;
  logic [7:0]  vga_R, vga_G, vga_B;

  always #5 clk_clk = ~clk_clk;

  squares_vga_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CLK_DIV(CLK_DIV), .N_SQ(N_SQ), .COORD_W(CW), .BG_COLOR(BG)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .wr_en(wr_en), .wr_sq(wr_sq), .wr_field(wr_field), .wr_data(wr_data),
    .frame_commit(frame_commit), .vga_CLK(vga_CLK),
    .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK), .vga_SYNC(vga_SYNC),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B)
  );

  typedef struct { int x; int y; int size; int color; } msq_t;

  msq_t           m_shadow [N_SQ];
  msq_t           m_active [N_SQ];
  logic [W-1:0]   exp_q[$];
  int             e_cnt, n_cnt;
  int             chk_cnt = 0;
  int             err_cnt = 0;

  function automatic logic [W-1:0] pixel_exp(input int h, input int v);
    logic hs, vs, act, found;
    logic [23:0] rgb;
    hs = !(h >= HA + HF && h < HA + HF + HSY);
    vs = !(v >= VA + VF && v < VA + VF + VSY);
    act = (h < HA) && (v < VA);
    rgb = BG;
    found = 1'b0;
    for (int i = 0; i < N_SQ; i++) begin
      if (!found && m_active[i].size != 0 &&
          h >= m_active[i].x && h < m_active[i].x + m_active[i].size &&
          v >= m_active[i].y && v < m_active[i].y + m_active[i].size) begin
        rgb = m_active[i].color[23:0];
        found = 1'b1;
      end
    end
    if (!act) rgb = '0;
    return {hs, vs, act, rgb};
  endfunction

  task automatic model_reset();
    e_cnt = 0;
    n_cnt = 0;
    for (int i = 0; i < N_SQ; i++) begin
      m_shadow[i] = '{0, 0, 0, 0};
      m_active[i] = '{0, 0, 0, 0};
    end
    exp_q.delete();
    exp_q.push_back(RESET_PIX);
    exp_q.push_back(RESET_PIX);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    assert (got === want) else begin
      err_cnt++;
      $error("FAIL %s: got=%h want=%h (tick %0d)", tag, got, want, n_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix"}, 32'({vga_HS, vga_VS, vga_BLANK, vga_R, vga_G, vga_B}), 32'(RESET_PIX));
    check({tag, "_commit"}, 32'(frame_commit), 32'(0));
    check({tag, "_vgaclk"}, 32'(vga_CLK), 32'(0));
  endtask

  // One clock: drive inputs, compare outputs, advance the model across the edge.
  task automatic step(input logic we, input logic [3:0] sq, input logic [1:0] fld,
                      input logic [23:0] data);
    int div, pos, idx;
    wr_en = we; wr_sq = sq; wr_field = fld; wr_data = data;
    div = e_cnt % CLK_DIV;
    check("pixel", 32'({vga_HS, vga_VS, vga_BLANK, vga_R, vga_G, vga_B}), 32'(exp_q[0]));
    check("frame_commit", 32'(frame_commit),
          32'(div == CLK_DIV - 1 && (n_cnt % FRAME) == COMMIT_POS));
    check("vga_clk", 32'(vga_CLK), 32'(div >= CLK_DIV / 2));
    check("vga_sync", 32'(vga_SYNC), 32'(0));
    @(posedge clk_clk);
    if (div == CLK_DIV - 1) begin
      pos = n_cnt % FRAME;
      exp_q.push_back(pixel_exp(pos % HT, pos / HT));
      void'(exp_q.pop_front());
      if (pos == COMMIT_POS) m_active = m_shadow;
      n_cnt++;
    end
    idx = int'(sq);
    if (we && idx < N_SQ) begin
      case (fld)
        2'd0: m_shadow[idx].x = int'(data[CW-1:0]);
        2'd1: m_shadow[idx].y = int'(data[CW-1:0]);
        2'd2: m_shadow[idx].size = int'(data[CW-1:0]);
        default: m_shadow[idx].color = int'(data);
      endcase
    end
    e_cnt++;
    @(negedge clk_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 2'd0, 24'd0);
  endtask

  task automatic wr(input int sq, input int fld, input int data);
    step(1'b1, 4'(sq), 2'(fld), 24'(data));
  endtask

  task automatic write_square(input int sq, input int x, input int y, input int size,
                              input int color);
    wr(sq, 0, x); wr(sq, 1, y); wr(sq, 2, size); wr(sq, 3, color);
  endtask

  // Advance until the next clock is the model's commit cycle.
  task automatic run_to_commit();
    for (int k = 0; k < FRAME * CLK_DIV + 2; k++) begin
      if ((e_cnt % CLK_DIV) == CLK_DIV - 1 && (n_cnt % FRAME) == COMMIT_POS) break;
      idle(1);
    end
  endtask

  initial begin
    // Power-on reset
    model_reset();
    repeat (3) @(negedge clk_clk);
    check_reset_outputs("por");
    reset_reset_n = 1'b1;

    // Empty screen: background inside the window, syncs and blanking only
    idle(FRAME * CLK_DIV + 100);

    // Single red square written mid-frame
    write_square(0, 5, 3, 4, 24'hFF0000);
    idle(2 * FRAME * CLK_DIV);

    // Overlap priority plus a square clipped at the right edge
    write_square(0, 8, 8, 5, 24'h00FF00);
    write_square(1, 10, 10, 6, 24'h0000FF);
    write_square(2, 30, 10, 40, 24'hFF0000);
    idle(2 * FRAME * CLK_DIV);

    // Write landing in the commit cycle, then an out-of-range index
    wr(3, 0, 1); wr(3, 1, 1); wr(3, 3, 24'hFFFFFF);
    run_to_commit();
    wr(3, 2, 3);
    wr(N_SQ, 2, 7);
    wr(N_SQ, 3, 24'h123456);
    idle(2 * FRAME * CLK_DIV);

    // Random attribute traffic
    repeat (40) begin
      wr($urandom_range(0, 15), $urandom_range(0, 3), int'($urandom_range(0, 24'hFFFFFF)));
      idle($urandom_range(0, 200));
    end
    idle(FRAME * CLK_DIV);

    // Asynchronous reset in the middle of a visible line
    for (int k = 0; k < FRAME * CLK_DIV + 2; k++) begin
      if ((n_cnt % FRAME) == 12 * HT + 10) break;
      idle(1);
    end
    #2 reset_reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge clk_clk);
    check_reset_outputs("held_rst");
    model_reset();
    reset_reset_n = 1'b1;
    idle(FRAME * CLK_DIV + 100);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/squares_vga_renderer.md
# squares_vga_renderer

Parametrised VGA pixel pipeline that draws up to N_SQ solid, axis-aligned squares over a background colour and drives the board VGA DAC pins directly. Timing, pixel-clock divide, square count and background are generics. Square attributes are written through a simple register port into shadow registers. Shadow registers commit atomically once per frame, so no frame ever shows a half-updated square. Sits between the game/control logic (keys, switches, PS/2) and the VGA connector.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33
- CLK_DIV, 2, clk_clk cycles per pixel (≥2)
- N_SQ, 4, number of squares (1..16)
- COORD_W, 10, coordinate/size width
- BG_COLOR, 24'h000000, {R,G,B} background
- clk_clk  in  1  system clock (one clock domain)
- reset_reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one per clk_clk cycle
- wr_sq  in  4  square index; index ≥ N_SQ ignored
- wr_field  in  2  0=X, 1=Y, 2=SIZE, 3=COLOR
- wr_data  in  24  X/Y/SIZE use [COORD_W-1:0]; COLOR uses {R[23:16],G[15:8],B[7:0]}
- frame_commit  out  1  one-clk_clk pulse when shadow→active copy occurs
- vga_CLK  out  1  pixel clock to DAC
- vga_HS, vga_VS  out  1  syncs, active low
- vga_BLANK  out  1  low during blanking
- vga_SYNC  out  1  constant 0
- vga_R, vga_G, vga_B  out  8  colour

## Operation
- Pixel tick: divider counts 0..CLK_DIV-1; tick when divider = CLK_DIV-1. vga_CLK = 1 while divider ≥ CLK_DIV/2, else 0.
- On each tick h advances 0..H_TOTAL-1 (H_TOTAL = sum of H_*); at wrap v advances 0..V_TOTAL-1, both wrapping to 0.
- HS low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS likewise on v. Active = h<H_ACTIVE && v<V_ACTIVE.
- Square i hits when size≠0, x ≤ h < x+size, y ≤ v < y+size. Sums computed in COORD_W+1 bits, so squares extending past the screen clip and never wrap to the left/top.
- Colour: lowest-index hit square wins; no hit → BG_COLOR; inactive → 0.
- Writes update shadow[wr_sq].field in the cycle wr_en is high; active registers unchanged.
- Commit: on the tick with h=0, v=V_ACTIVE (first blanking line), active ← shadow for all squares; frame_commit pulses that cycle.
- A write landing in the commit cycle goes to shadow only; commit copies pre-write shadow, and the write appears next frame.
- Reset: all counters 0, shadow and active 0 (size 0 = disabled), frame_commit 0, vga_CLK 0, HS/VS 1, BLANK 0, SYNC 0, RGB 0. Reset mid-frame restarts at h=v=0 with no commit pulse.

## Timing
- Pipeline two pixel ticks: stage 1 registers hit vector; stage 2 registers RGB. HS/VS/BLANK are delayed two ticks to stay aligned with RGB.
- Outputs change only on tick cycles, except vga_CLK and frame_commit.
- Defaults: 800×525 ticks per frame, 840 000 clk_clk cycles at CLK_DIV=2.
- Write-to-display latency: from commit, first visible at next frame's h=0,v=0 plus 2 ticks.

## Structure
- Package squares_vga_pkg: timing defaults, field codes FLD_X/FLD_Y/FLD_SIZE/FLD_COLOR, square struct {x, y, size, color}.
- Sub-module squares_vga_timing: divider, h/v counters, raw HS/VS/active, commit strobe. Top holds register file, hit/priority, output pipeline.

## Test plan
- Reset, release, no writes → every active pixel RGB=000000, BLANK high only in 640×480 window, HS low 96 ticks/line, VS low 2 lines/frame, frame period 840 000 clks.
- Square 0 at X=100, Y=50, SIZE=20, COLOR=FF0000 written mid-frame → unchanged this frame; frame_commit at v=480; next frame, pixels (100..119, 50..69) red, (120,50) background.
- Squares 0 and 1 overlap at (10,10); sq0 green, sq1 blue → (10,10) green.
- Square X=630, SIZE=20 → red drawn for h=630..639 only, no pixels at h=0..9.
- Write in the exact commit cycle → value absent next frame, present the frame after; wr_sq=N_SQ write has no effect.
- Assert reset_reset_n mid-line → outputs return to reset values asynchronously; after release, counters start at 0 and active squares are all disabled.
